// File: rtl/nios2_freertos_led_sequencer.sv
// Avalon-MM LED bank controller. It holds a manual pattern and runs a hardware
// sequencer that blinks between two patterns or rotates one, paced by a prescaler.
module nios2_freertos_led_sequencer #(
    parameter int DATA_WIDTH   = 27,
    parameter int PERIOD_WIDTH = 24,
    parameter int STEPS_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_PATB   = 3'd3;
    localparam logic [2:0] ADDR_STEPS  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [3:0]              ctrl_q, ctrl_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [DATA_WIDTH-1:0]   patb_q, patb_d;
    logic [STEPS_WIDTH-1:0]  steps_q, steps_d;
    logic                    done_q, done_d;
    logic                    irq_q, irq_d;
    logic [DATA_WIDTH-1:0]   seq_q, seq_d;
    logic [PERIOD_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [STEPS_WIDTH-1:0]  step_cnt_q, step_cnt_d;

    logic                    wr_en;
    logic                    ctrl_wr;
    logic [PERIOD_WIDTH-1:0] eff_period;
    logic                    step_fire;
    logic [STEPS_WIDTH-1:0]  step_cnt_inc;

    assign wr_en        = chipselect && !write_n;
    assign ctrl_wr      = wr_en && (address == ADDR_CTRL);
    assign eff_period   = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
    // Compare with >= so that shrinking PERIOD below the current count fires at once.
    assign step_fire    = (tick_cnt_q >= (eff_period - PERIOD_WIDTH'(1)));
    assign step_cnt_inc = step_cnt_q + STEPS_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        patb_d     = patb_q;
        steps_d    = steps_q;
        done_d     = done_q;
        seq_d      = seq_q;
        tick_cnt_d = tick_cnt_q;
        step_cnt_d = step_cnt_q;

        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d   = writedata[DATA_WIDTH-1:0];
                ADDR_CTRL:   ctrl_d   = writedata[3:0];
                ADDR_PERIOD: period_d = writedata[PERIOD_WIDTH-1:0];
                ADDR_PATB:   patb_d   = writedata[DATA_WIDTH-1:0];
                ADDR_STEPS:  steps_d  = writedata[STEPS_WIDTH-1:0];
                ADDR_STATUS: if (writedata[1]) done_d = 1'b0;
                default:     ;
            endcase
        end

        // The done-set below comes after the W1C above so that setting wins.
        case (state_q)
            IDLE: begin
                if (ctrl_wr && writedata[0]) begin
                    state_d    = RUN;
                    seq_d      = data_q;
                    tick_cnt_d = '0;
                    step_cnt_d = '0;
                end
            end
            RUN: begin
                if (ctrl_wr) begin
                    if (writedata[0]) begin
                        seq_d      = data_q;
                        tick_cnt_d = '0;
                        step_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (step_fire) begin
                    tick_cnt_d = '0;
                    step_cnt_d = step_cnt_inc;
                    if (ctrl_q[1]) begin
                        seq_d = {seq_q[DATA_WIDTH-2:0], seq_q[DATA_WIDTH-1]};
                    end else begin
                        seq_d = (seq_q == data_q) ? patb_q : data_q;
                    end
                    if (ctrl_q[2] && ((steps_q == '0) || (step_cnt_inc == steps_q))) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        ctrl_d[0] = 1'b0;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + PERIOD_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        irq_d = done_d && ctrl_d[3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            ctrl_q     <= '0;
            period_q   <= '0;
            patb_q     <= '0;
            steps_q    <= '0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            seq_q      <= '0;
            tick_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            patb_q     <= patb_d;
            steps_q    <= steps_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            seq_q      <= seq_d;
            tick_cnt_q <= tick_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_CTRL:   readdata = 32'(ctrl_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_PATB:   readdata = 32'(patb_q);
            ADDR_STEPS:  readdata = 32'(steps_q);
            ADDR_STATUS: readdata = (32'(step_cnt_q) << 8) | {30'd0, done_q, (state_q == RUN)};
            default:     readdata = '0;
        endcase
    end

    assign out_port = (state_q == RUN) ? seq_q : data_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_freertos_led_sequencer.sv
// Directed bench for the LED sequencer: register table plus blink, rotate,
// oneshot, live PERIOD change and mid-run reset sequences.
module tb_nios2_freertos_led_sequencer;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [26:0] out_port;
    logic        irq;

    int checks;
    int failures;

    nios2_freertos_led_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_read;
        logic [26:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    // One bus write; returns 1ns after the capturing edge.
    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [26:0] exp;

        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 3'(i), 32'h0, 32'h0, 27'h0});
        vecs.push_back('{1'b1, 3'd0, 32'h05A5_A5A5, 32'h05A5_A5A5, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h00FF_FFFF, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h07FF_FFFF, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd4, 32'h0000_01FF, 32'h0000_00FF, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd6, 32'h0000_1234, 32'h0000_0000, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_000C, 32'h0000_000C, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_00F0, 32'h0000_0000, 27'h5A5A5A5});
        vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h07FF_FFFF, 27'h7FFFFFF});

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_irq", 32'(irq), 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) applyStimulus(vecs[i].addr, vecs[i].wdata);
            readReg(vecs[i].addr, rd);
            checkOutput($sformatf("vec%0d_read", i), rd, vecs[i].exp_read);
            checkOutput($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
        end

        // Blink between 0x1 and 0x7FFFFFF every 4 clocks.
        applyStimulus(3'd0, 32'h1);
        applyStimulus(3'd3, 32'h07FF_FFFF);
        applyStimulus(3'd2, 32'd4);
        applyStimulus(3'd1, 32'h1);
        checkOutput("blink_e0", 32'(out_port), 32'h1);
        for (int k = 1; k <= 12; k++) begin
            nextEdge();
            exp = (((k / 4) % 2) == 1) ? 27'h7FFFFFF : 27'h1;
            checkOutput($sformatf("blink_e%0d", k), 32'(out_port), 32'(exp));
        end
        applyStimulus(3'd1, 32'h0);
        checkOutput("blink_stop_out", 32'(out_port), 32'h1);
        readReg(3'd5, rd);
        checkOutput("blink_stop_busy", 32'(rd[0]), 32'h0);

        // Rotate every clock, including the wrap from bit 26 to bit 0.
        applyStimulus(3'd0, 32'h0400_0000);
        applyStimulus(3'd2, 32'h0);
        applyStimulus(3'd1, 32'h3);
        checkOutput("rot_e0", 32'(out_port), 32'h0400_0000);
        nextEdge();
        checkOutput("rot_e1", 32'(out_port), 32'h1);
        nextEdge();
        checkOutput("rot_e2", 32'(out_port), 32'h2);
        nextEdge();
        checkOutput("rot_e3", 32'(out_port), 32'h4);
        applyStimulus(3'd1, 32'h0);

        // Oneshot rotate of 3 steps, 2 clocks each, with irq enabled.
        applyStimulus(3'd0, 32'h1);
        applyStimulus(3'd4, 32'd3);
        applyStimulus(3'd2, 32'd2);
        applyStimulus(3'd1, 32'hF);
        nextEdge();
        checkOutput("os_e1_out", 32'(out_port), 32'h1);
        nextEdge();
        checkOutput("os_e2_out", 32'(out_port), 32'h2);
        nextEdge();
        nextEdge();
        checkOutput("os_e4_out", 32'(out_port), 32'h4);
        nextEdge();
        readReg(3'd5, rd);
        checkOutput("os_e5_status", rd, 32'h0000_0201);
        checkOutput("os_e5_irq", 32'(irq), 32'h0);
        nextEdge();
        readReg(3'd5, rd);
        checkOutput("os_done_status", rd, 32'h0000_0302);
        checkOutput("os_done_irq", 32'(irq), 32'h1);
        checkOutput("os_done_out", 32'(out_port), 32'h1);
        readReg(3'd1, rd);
        checkOutput("os_done_ctrl", rd, 32'h0000_000E);
        nextEdge();
        readReg(3'd5, rd);
        checkOutput("os_idle_status", rd, 32'h0000_0302);
        checkOutput("os_idle_irq", 32'(irq), 32'h1);
        applyStimulus(3'd5, 32'h2);
        checkOutput("os_w1c_irq", 32'(irq), 32'h0);
        readReg(3'd5, rd);
        checkOutput("os_w1c_status", rd, 32'h0000_0300);

        // Oneshot with STEPS=0 completes on the very first step.
        applyStimulus(3'd4, 32'd0);
        applyStimulus(3'd2, 32'd0);
        applyStimulus(3'd1, 32'hD);
        nextEdge();
        readReg(3'd5, rd);
        checkOutput("os0_status", rd, 32'h0000_0102);
        checkOutput("os0_irq", 32'(irq), 32'h1);
        applyStimulus(3'd5, 32'h2);

        // Shrink PERIOD from 100 to 2 while tick_cnt is 50.
        applyStimulus(3'd0, 32'h1);
        applyStimulus(3'd3, 32'h2);
        applyStimulus(3'd2, 32'd100);
        applyStimulus(3'd1, 32'h1);
        repeat (50) @(posedge clk);
        applyStimulus(3'd2, 32'd2);
        checkOutput("per_e51_out", 32'(out_port), 32'h1);
        readReg(3'd5, rd);
        checkOutput("per_e51_status", rd, 32'h0000_0001);
        nextEdge();
        checkOutput("per_e52_out", 32'(out_port), 32'h2);
        nextEdge();
        checkOutput("per_e53_out", 32'(out_port), 32'h2);
        nextEdge();
        checkOutput("per_e54_out", 32'(out_port), 32'h1);
        nextEdge();
        checkOutput("per_e55_out", 32'(out_port), 32'h1);
        nextEdge();
        checkOutput("per_e56_out", 32'(out_port), 32'h2);
        readReg(3'd5, rd);
        checkOutput("per_e56_status", rd, 32'h0000_0301);

        // Reset in the middle of a run with step_cnt at 5.
        applyStimulus(3'd2, 32'd0);
        applyStimulus(3'd1, 32'h9);
        repeat (5) nextEdge();
        readReg(3'd5, rd);
        checkOutput("rst_pre_status", rd, 32'h0000_0501);
        @(negedge clk);
        reset = 1'b1;
        nextEdge();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            readReg(3'(i), rd);
            checkOutput($sformatf("rst_read%0d", i), rd, 32'h0);
        end
        checkOutput("rst_out", 32'(out_port), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        repeat (4) nextEdge();
        readReg(3'd5, rd);
        checkOutput("rst_stay_idle", rd, 32'h0);
        checkOutput("rst_stay_out", 32'(out_port), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
